// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and slave FSM states for the data-side SRAM responder.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'd0;
   localparam logic [1:0] HTRANS_BUSY   = 2'd1;
   localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
   localparam logic [1:0] HTRANS_SEQ    = 2'd3;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WAIT = 3'd1,
      S_DATA = 3'd2,
      S_ERR1 = 3'd3,
      S_ERR2 = 3'd4
   } slave_state_t;

   // Lane enables for an already-validated (aligned, size <= word) access.
   function automatic logic [3:0] byte_enables(input logic [2:0] size, input logic [1:0] lane);
      logic [3:0] be;
      case (size)
         HSIZE_BYTE: be = 4'b0001 << lane;
         HSIZE_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
         default:    be = 4'b1111;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Word-wide storage built from four byte-lane arrays: per-lane write enable,
// asynchronous read, contents never reset.
module ahb_sram_array #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic [3:0]        we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [31:0]       wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [31:0]       rdata
);

   localparam int DEPTH = 2 ** ADDR_W;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] mem [DEPTH];

         always_ff @(posedge clk) begin
            if (we[gi]) begin
               mem[waddr] <= wdata[8*gi +: 8];
            end
         end

         assign rdata[8*gi +: 8] = mem[raddr];
      end
   endgenerate

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder with programmable wait states and two-cycle ERROR.
// Define AHB_SRAM_ROM_EN to make the lowest ROM_WORDS words read-only.
module ahb_sram_slave
   import ahb_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int WAIT_STATES = 1,
   parameter int ROM_WORDS   = 16
) (
   input  logic        hclk,
   input  logic        hrst,
   input  logic        hsel,
   input  logic [31:0] haddr,
   input  logic        hwrite,
   input  logic [2:0]  hsize,
   input  logic [2:0]  hburst,
   input  logic [6:0]  hprot,
   input  logic [1:0]  htrans,
   input  logic        hmastlock,
   input  logic [31:0] hwdata,
   input  logic        hready,
   output logic        hreadyout,
   output logic        hresp,
   output logic [31:0] hrdata
);

   slave_state_t      state_reg, state_next;
   logic [3:0]        cnt_reg, cnt_next;
   logic [ADDR_W+1:0] addr_reg;
   logic              write_reg;
   logic [2:0]        size_reg;
   logic [31:0]       hrdata_reg;

   logic              accept;
   logic              capture;
   logic              req_err;
   logic              wr_en;
   logic [3:0]        we;
   logic [31:0]       rdata;
   logic              unused_ok;

   assign unused_ok = ^{hburst, hprot, hmastlock};

   assign accept = hsel && hready && htrans[1];

   // Request checks use the live address-phase signals, decided at acceptance.
   always_comb begin
      req_err = 1'b0;
      if (hsize > HSIZE_WORD) begin
         req_err = 1'b1;
      end
      if ((hsize == HSIZE_HALF) && haddr[0]) begin
         req_err = 1'b1;
      end
      if ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00)) begin
         req_err = 1'b1;
      end
      if (haddr[31:ADDR_W+2] != '0) begin
         req_err = 1'b1;
      end
`ifdef AHB_SRAM_ROM_EN
      if (hwrite && (haddr[31:2] < 30'(ROM_WORDS))) begin
         req_err = 1'b1;
      end
`endif
   end

`ifndef AHB_SRAM_ROM_EN
   localparam int ROM_WORDS_UNUSED = ROM_WORDS;
`endif

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      capture    = 1'b0;
      hreadyout  = 1'b1;
      hresp      = HRESP_OKAY;
      case (state_reg)
         S_IDLE, S_DATA, S_ERR2: begin
            if (state_reg == S_ERR2) begin
               hresp = HRESP_ERROR;
            end
            if (accept) begin
               capture = 1'b1;
               if (req_err) begin
                  state_next = S_ERR1;
               end else if (WAIT_STATES > 0) begin
                  state_next = S_WAIT;
                  cnt_next   = 4'(WAIT_STATES);
               end else begin
                  state_next = S_DATA;
               end
            end else begin
               state_next = S_IDLE;
            end
         end
         S_WAIT: begin
            hreadyout = 1'b0;
            cnt_next  = cnt_reg - 4'd1;
            if (cnt_reg == 4'd1) begin
               state_next = S_DATA;
            end
         end
         S_ERR1: begin
            hreadyout  = 1'b0;
            hresp      = HRESP_ERROR;
            state_next = S_ERR2;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Read data is live only in a read's data phase; elsewhere the last value is held.
   assign hrdata = ((state_reg == S_DATA) && !write_reg) ? rdata : hrdata_reg;

   always_ff @(posedge hclk) begin
      if (hrst) begin
         state_reg  <= S_IDLE;
         cnt_reg    <= '0;
         addr_reg   <= '0;
         write_reg  <= 1'b0;
         size_reg   <= HSIZE_BYTE;
         hrdata_reg <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (capture) begin
            addr_reg  <= haddr[ADDR_W+1:0];
            write_reg <= hwrite;
            size_reg  <= hsize;
         end
         if (capture && req_err && !hwrite) begin
            hrdata_reg <= '0;
         end else begin
            hrdata_reg <= hrdata;
         end
      end
   end

   // Commit on the edge that ends the data phase; a reset on that edge abandons it.
   assign wr_en = (state_reg == S_DATA) && write_reg && !hrst;
   assign we    = wr_en ? byte_enables(size_reg, addr_reg[1:0]) : 4'b0000;

   ahb_sram_array #(
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk   (hclk),
      .we    (we),
      .waddr (addr_reg[ADDR_W+1:2]),
      .wdata (hwdata),
      .raddr (addr_reg[ADDR_W+1:2]),
      .rdata (rdata)
   );

endmodule
